// File: rtl/board_store.sv
// Dark-chess 4x8 board register with write port, live-piece counters and
// optional LFSR Fisher-Yates shuffle on reset/new game (enable with BOARD_SHUFFLE_EN).
module board_store
`ifdef BOARD_SHUFFLE_EN
#(
    parameter logic [15:0] LFSR_SEED = 16'hACE1
)
`endif
(
    input  logic         CLK,
    input  logic         RESET_N,
    input  logic         new_game,
    input  logic         wr_en,
    input  logic [4:0]   wr_addr,
    input  logic [4:0]   wr_piece,
    output logic [159:0] board_output,
    output logic         ready,
    output logic [4:0]   red_left,
    output logic [4:0]   black_left
);

    typedef enum logic [1:0] {
        ST_FILL    = 2'd0,
`ifdef BOARD_SHUFFLE_EN
        ST_SHUFFLE = 2'd2,
`endif
        ST_READY   = 2'd1
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [31:0][4:0]  r_board;
    logic              r_ready;
    logic [4:0]        r_red_left;
    logic [4:0]        r_black_left;
    logic [5:0]        w_red_cnt;
    logic [5:0]        w_black_cnt;
    logic              w_do_fill;
    logic              w_do_write;
`ifdef BOARD_SHUFFLE_EN
    logic [15:0]       r_lfsr;
    logic [15:0]       w_lfsr_nxt;
    logic [4:0]        r_i;
    logic [4:0]        w_j;
    logic              w_do_swap;
`endif

    // Canonical covered layout: index {color, k}, k selects the piece type.
    function automatic logic [4:0] canon_piece(input logic [4:0] n);
        logic [2:0] t;
        if      (n[3:0] < 4'd5)  t = 3'b001;
        else if (n[3:0] < 4'd7)  t = 3'b010;
        else if (n[3:0] < 4'd9)  t = 3'b011;
        else if (n[3:0] < 4'd11) t = 3'b100;
        else if (n[3:0] < 4'd13) t = 3'b101;
        else if (n[3:0] < 4'd15) t = 3'b110;
        else                     t = 3'b111;
        return {n[4], t, 1'b0};
    endfunction

`ifdef BOARD_SHUFFLE_EN
    assign w_lfsr_nxt = {1'b0, r_lfsr[15:1]} ^ (r_lfsr[0] ? 16'hB400 : 16'h0000);
    assign w_j        = r_lfsr[4:0];
`endif

    always_comb begin
        w_state_nxt = r_state;
        w_do_fill   = 1'b0;
        w_do_write  = 1'b0;
`ifdef BOARD_SHUFFLE_EN
        w_do_swap   = 1'b0;
`endif
        case (r_state)
            ST_FILL: begin
                w_do_fill = 1'b1;
`ifdef BOARD_SHUFFLE_EN
                w_state_nxt = ST_SHUFFLE;
`else
                w_state_nxt = ST_READY;
`endif
            end
`ifdef BOARD_SHUFFLE_EN
            ST_SHUFFLE: begin
                // Rejection sampling keeps j uniform over 0..i.
                if (w_j <= r_i) begin
                    w_do_swap = 1'b1;
                    if (r_i == 5'd1) w_state_nxt = ST_READY;
                end
            end
`endif
            ST_READY: begin
                if (new_game)   w_state_nxt = ST_FILL;
                else if (wr_en) w_do_write  = 1'b1;
            end
            default: w_state_nxt = ST_FILL;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RESET_N) begin
            r_state <= ST_FILL;
            r_ready <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_ready <= (w_state_nxt == ST_READY);
        end
    end

    always_ff @(posedge CLK) begin
        if (!RESET_N) begin
            r_board <= '0;
        end else if (w_do_fill) begin
            for (int n = 0; n < 32; n++) r_board[n] <= canon_piece(5'(n));
`ifdef BOARD_SHUFFLE_EN
        end else if (w_do_swap) begin
            r_board[r_i] <= r_board[w_j];
            r_board[w_j] <= r_board[r_i];
`endif
        end else if (w_do_write) begin
            r_board[wr_addr] <= wr_piece;
        end
    end

`ifdef BOARD_SHUFFLE_EN
    always_ff @(posedge CLK) begin
        if (!RESET_N) begin
            r_lfsr <= LFSR_SEED;
            r_i    <= 5'd31;
        end else begin
            r_lfsr <= w_lfsr_nxt;
            if (w_do_fill)      r_i <= 5'd31;
            else if (w_do_swap) r_i <= r_i - 5'd1;
        end
    end
`endif

    always_comb begin
        w_red_cnt   = '0;
        w_black_cnt = '0;
        for (int n = 0; n < 32; n++) begin
            if (r_board[n][3:1] != 3'b000) begin
                if (r_board[n][4]) w_black_cnt = w_black_cnt + 6'd1;
                else               w_red_cnt   = w_red_cnt + 6'd1;
            end
        end
    end

    // A fully overwritten board could exceed 31 of one colour; clamp rather than wrap.
    always_ff @(posedge CLK) begin
        if (!RESET_N) begin
            r_red_left   <= '0;
            r_black_left <= '0;
        end else begin
            r_red_left   <= (w_red_cnt   > 6'd31) ? 5'd31 : w_red_cnt[4:0];
            r_black_left <= (w_black_cnt > 6'd31) ? 5'd31 : w_black_cnt[4:0];
        end
    end

    assign board_output = r_board;
    assign ready        = r_ready;
    assign red_left     = r_red_left;
    assign black_left   = r_black_left;

endmodule

// File: tb/tb_board_store.sv
// Randomized self-checking bench for board_store against a square-array reference model.
module tb_board_store;

    localparam logic [15:0] SEED = 16'hACE1;

    logic         CLK;
    logic         RESET_N;
    logic         new_game;
    logic         wr_en;
    logic [4:0]   wr_addr;
    logic [4:0]   wr_piece;
    logic [159:0] board_output;
    logic         ready;
    logic [4:0]   red_left;
    logic [4:0]   black_left;

    int n_chk  = 0;
    int n_fail = 0;

    logic [4:0]  m_board [32];
    logic [15:0] m_lfsr;

    board_store dut (
        .CLK          (CLK),
        .RESET_N      (RESET_N),
        .new_game     (new_game),
        .wr_en        (wr_en),
        .wr_addr      (wr_addr),
        .wr_piece     (wr_piece),
        .board_output (board_output),
        .ready        (ready),
        .red_left     (red_left),
        .black_left   (black_left)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [159:0] obs, input logic [159:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [4:0] canon(input int n);
        int k;
        int t;
        k = n % 16;
        t = (k < 5) ? 1 : (k < 7) ? 2 : (k < 9) ? 3 : (k < 11) ? 4 :
            (k < 13) ? 5 : (k < 15) ? 6 : 7;
        return 5'((n / 16) * 16 + t * 2);
    endfunction

    function automatic logic [159:0] pack_model();
        logic [159:0] pk;
        pk = '0;
        for (int n = 0; n < 32; n++) pk[n*5 +: 5] = m_board[n];
        return pk;
    endfunction

    function automatic int cnt(input int c);
        int s;
        s = 0;
        for (int n = 0; n < 32; n++)
            if (m_board[n][3:1] != 3'b000 && int'(m_board[n][4]) == c) s++;
        return s;
    endfunction

    function automatic logic [15:0] lfsr_step(input logic [15:0] l);
        return (l >> 1) ^ (l[0] ? 16'hB400 : 16'h0000);
    endfunction

    // LFSR free-runs whenever out of reset; mirrors the shuffle's entropy source.
    always @(posedge CLK) m_lfsr <= !RESET_N ? SEED : lfsr_step(m_lfsr);

    task automatic model_canon();
        for (int n = 0; n < 32; n++) m_board[n] = canon(n);
    endtask

    // Fisher-Yates with rejection, starting from the LFSR value seen in the fill cycle.
    task automatic model_shuffle(input logic [15:0] l_fill);
        logic [15:0] l;
        logic [4:0]  tmp;
        int i, j;
        model_canon();
        l = lfsr_step(l_fill);
        i = 31;
        while (i >= 1) begin
            j = int'(l[4:0]);
            if (j <= i) begin
                tmp = m_board[i]; m_board[i] = m_board[j]; m_board[j] = tmp;
                i--;
            end
            l = lfsr_step(l);
        end
    endtask

    task automatic step(input logic w, input logic [4:0] a, input logic [4:0] p, input logic ng);
        int er, eb;
        @(negedge CLK);
        wr_en = w; wr_addr = a; wr_piece = p; new_game = ng;
        er = cnt(0);
        eb = cnt(1);
        @(posedge CLK); #1;
        if (w && !ng) m_board[a] = p;
        wr_en = 1'b0; new_game = 1'b0;
        chk("board", board_output, pack_model());
        chk("red_left", red_left, er);
        chk("black_left", black_left, eb);
    endtask

    task automatic wait_ready(input int budget);
        int k;
        k = 0;
        while (!ready && k < budget) begin
            @(posedge CLK); #1;
            k++;
        end
        wr_en = 1'b0; new_game = 1'b0;
        chk("ready_timeout", ready, 1'b1);
    endtask

    task automatic check_reset_state();
        chk("rst_board", board_output, '0);
        chk("rst_ready", ready, 1'b0);
        chk("rst_red", red_left, 5'd0);
        chk("rst_black", black_left, 5'd0);
    endtask

    task automatic power_on_check();
`ifdef BOARD_SHUFFLE_EN
        int hd [32];
        int hc [32];
        wait_ready(2000);
        model_shuffle(SEED);
        chk("shuffle_layout", board_output, pack_model());
        for (int v = 0; v < 32; v++) begin hd[v] = 0; hc[v] = 0; end
        for (int n = 0; n < 32; n++) begin
            hd[board_output[n*5 +: 5]]++;
            hc[canon(n)]++;
        end
        for (int v = 0; v < 32; v++)
            if (hc[v] != 0 || hd[v] != 0) chk($sformatf("multiset_%0d", v), hd[v], hc[v]);
        @(posedge CLK); #1;
`else
        @(posedge CLK); #1;
        @(posedge CLK); #1;
        chk("ready_cycle2", ready, 1'b1);
        model_canon();
        chk("sq0", board_output[4:0], 5'b0_001_0);
        chk("sq15", board_output[79:75], 5'b0_111_0);
        chk("sq31", board_output[159:155], 5'b1_111_0);
        chk("canon_layout", board_output, pack_model());
`endif
        chk("red16", red_left, 5'd16);
        chk("black16", black_left, 5'd16);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] l_snap;
        RESET_N = 1'b0; new_game = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_piece = '0;
        repeat (3) @(posedge CLK);
        #1;
        check_reset_state();

        // write while held in reset must be ignored
        @(negedge CLK); wr_en = 1'b1; wr_addr = 5'd4; wr_piece = 5'h1F;
        @(posedge CLK); #1;
        chk("rst_write_ignored", board_output, '0);
        wr_en = 1'b0;

        @(negedge CLK); RESET_N = 1'b1;
        power_on_check();

        // single write, exact bit slice
        step(1'b1, 5'b01_010, 5'b0_100_1, 1'b0);
        chk("sq10_bits", board_output[54:50], 5'b01001);

        // capture pair: move lands, source cleared on the next cycle
        step(1'b1, 5'd3, 5'b1_100_1, 1'b0);
        step(1'b1, 5'd2, 5'b0_000_0, 1'b0);
        step(1'b0, 5'd0, 5'd0, 1'b0);
        chk("capture_red", red_left, cnt(0));

        // back-to-back to the same square; last one wins
        step(1'b1, 5'd7, 5'b1_011_1, 1'b0);
        step(1'b1, 5'd7, 5'b0_110_1, 1'b0);
        // colour 1 with empty type counts toward neither colour
        step(1'b1, 5'd20, 5'b1_000_0, 1'b0);
        step(1'b0, 5'd0, 5'd0, 1'b0);

        for (int r = 0; r < 60; r++)
            step(1'($urandom_range(0, 1)), 5'($urandom), 5'($urandom), 1'b0);

        // new_game together with a write: write dropped, ready falls
        step(1'b1, 5'd5, 5'b1_111_1, 1'b1);
        chk("ng_ready_low", ready, 1'b0);
`ifdef BOARD_SHUFFLE_EN
        l_snap = m_lfsr;
        @(negedge CLK);
        wr_en = 1'b1; wr_addr = 5'($urandom); wr_piece = 5'($urandom); new_game = 1'b1;
        wait_ready(2000);
        model_shuffle(l_snap);
        chk("reshuffle_layout", board_output, pack_model());
`else
        l_snap = '0;
        // wr_en and new_game during FILL are both ignored
        @(negedge CLK); wr_en = 1'b1; wr_addr = 5'd0; wr_piece = 5'h1F; new_game = 1'b1;
        @(posedge CLK); #1;
        wr_en = 1'b0; new_game = 1'b0;
        model_canon();
        chk("refill_layout", board_output, pack_model());
        chk("refill_ready", ready, 1'b1);
        @(posedge CLK); #1;
        chk("ng_not_queued", ready, 1'b1);
        chk("refill_hold", board_output, pack_model());
`endif
        step(1'b1, 5'd31, 5'b0_001_1, 1'b0);
        step(1'b0, 5'd0, 5'd0, 1'b0);

        // reset pulse while the board is being rebuilt replays power-on
        step(1'b0, 5'd0, 5'd0, 1'b1);
        repeat (4) @(posedge CLK);
        @(negedge CLK); RESET_N = 1'b0;
        @(posedge CLK); #1;
        check_reset_state();
        @(negedge CLK); RESET_N = 1'b1;
        power_on_check();
        step(1'b1, 5'd0, 5'b1_010_1, 1'b0);
        step(1'b0, 5'd0, 5'd0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
